// File: rtl/tap_collector.sv
// Collects NUM_TAPS legal tap exponents over a valid/ready stream and packs them
// into a slot vector for the LFSR configuration register, forcing MAX_POW into slot 0 if absent.
module tap_collector #(
    parameter int NUM_TAPS = 15,
    parameter int DIN_W    = 4,
    parameter int SLOT_W   = 8,
    parameter int MAX_POW  = 15,
    parameter int DEDUP    = 1,
    parameter int CNT_W    = $clog2(NUM_TAPS + 1)
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       start,
    input  logic [DIN_W-1:0]           din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [NUM_TAPS*SLOT_W-1:0] taps,
    output logic [CNT_W-1:0]           tap_count,
    output logic                       reject,
    output logic                       done,
    output logic [1:0]                 state_dbg
);

    // Handshake: din is taken on a rising edge where din_valid && din_ready;
    // din_ready depends only on state and start, never on din or din_valid.

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FIX     = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q [NUM_TAPS];
    logic [SLOT_W-1:0]   slot_d [NUM_TAPS];
    logic [CNT_W-1:0]    tap_count_q, tap_count_d;
    logic                seen_max_q, seen_max_d;
    logic                reject_q, reject_d;
    logic                done_q, done_d;

    logic [SLOT_W-1:0]   din_ext;
    logic                is_dup;
    logic                is_bad;

    assign din_ext   = SLOT_W'(din);
    assign din_ready = (state_q == S_COLLECT) && !start;

    // Only slots filled before this cycle take part; unfilled slots hold 0,
    // which is rejected on its own anyway.
    always_comb begin
        is_dup = 1'b0;
        if (DEDUP != 0) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if ((CNT_W'(i) < tap_count_q) && (slot_q[i] == din_ext)) begin
                    is_dup = 1'b1;
                end
            end
        end
    end

    assign is_bad = (din == '0) || (int'(din) > MAX_POW) || is_dup;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        tap_count_d = tap_count_q;
        seen_max_d  = seen_max_q;
        reject_d    = 1'b0;
        done_d      = done_q;
        if (start) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                slot_d[i] = '0;
            end
            tap_count_d = '0;
            seen_max_d  = 1'b0;
            done_d      = 1'b0;
            state_d     = S_COLLECT;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (din_valid) begin
                        if (is_bad) begin
                            reject_d = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_TAPS; i++) begin
                                if (CNT_W'(i) == tap_count_q) begin
                                    slot_d[i] = din_ext;
                                end
                            end
                            tap_count_d = tap_count_q + CNT_W'(1);
                            if (int'(din) == MAX_POW) begin
                                seen_max_d = 1'b1;
                            end
                            if (tap_count_q == CNT_W'(NUM_TAPS - 1)) begin
                                state_d = S_FIX;
                            end
                        end
                    end
                end
                S_FIX: begin
                    if (!seen_max_q) begin
                        slot_d[0] = SLOT_W'(MAX_POW);
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_COLLECT;
            for (int i = 0; i < NUM_TAPS; i++) begin
                slot_q[i] <= '0;
            end
            tap_count_q <= '0;
            seen_max_q  <= 1'b0;
            reject_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            tap_count_q <= tap_count_d;
            seen_max_q  <= seen_max_d;
            reject_q    <= reject_d;
            done_q      <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
        assign taps[g*SLOT_W +: SLOT_W] = slot_q[g];
    end

    assign tap_count = tap_count_q;
    assign reject    = reject_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tap_collector.sv
// Bench for tap_collector: two instances (DEDUP=1 and DEDUP=0) share one stimulus
// stream and are checked each cycle against a list-based reference model.
module tb_tap_collector;

    localparam int NT  = 4;
    localparam int MAXP = 15;

    localparam int PH_COLLECT = 0;
    localparam int PH_FIX     = 1;
    localparam int PH_DONE    = 2;

    logic        clk;
    logic        res;
    logic        start;
    logic [3:0]  din;
    logic        din_valid;

    logic        rdy0, rdy1;
    logic [31:0] taps0, taps1;
    logic [2:0]  cnt0, cnt1;
    logic        rej0, rej1;
    logic        done0, done1;
    logic [1:0]  st0, st1;

    int n_tests;
    int n_fail;

    // reference model, index 0 = dedup instance, 1 = repeats allowed
    int mvals  [2][NT];
    int mcnt   [2];
    int mphase [2];
    bit mrej   [2];
    bit mdone  [2];

    tap_collector #(.NUM_TAPS(NT), .DIN_W(4), .SLOT_W(8), .MAX_POW(MAXP), .DEDUP(1)) u_dut (
        .clk(clk), .res(res), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .taps(taps0), .tap_count(cnt0), .reject(rej0),
        .done(done0), .state_dbg(st0)
    );

    tap_collector #(.NUM_TAPS(NT), .DIN_W(4), .SLOT_W(8), .MAX_POW(MAXP), .DEDUP(0)) u_nd (
        .clk(clk), .res(res), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .taps(taps1), .tap_count(cnt1), .reject(rej1),
        .done(done1), .state_dbg(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NT; k++) mvals[m][k] = 0;
            mcnt[m]   = 0;
            mphase[m] = PH_COLLECT;
            mrej[m]   = 1'b0;
            mdone[m]  = 1'b0;
        end
    endfunction

    function automatic void model_edge(input int m, input bit s, input bit v, input int d);
        bit dup;
        bit has_max;
        mrej[m] = 1'b0;
        if (s) begin
            for (int k = 0; k < NT; k++) mvals[m][k] = 0;
            mcnt[m]   = 0;
            mphase[m] = PH_COLLECT;
            mdone[m]  = 1'b0;
        end else if (mphase[m] == PH_FIX) begin
            has_max = 1'b0;
            for (int k = 0; k < NT; k++) if (mvals[m][k] == MAXP) has_max = 1'b1;
            if (!has_max) mvals[m][0] = MAXP;
            mphase[m] = PH_DONE;
            mdone[m]  = 1'b1;
        end else if (mphase[m] == PH_COLLECT && v) begin
            dup = 1'b0;
            for (int k = 0; k < mcnt[m]; k++) if (mvals[m][k] == d) dup = 1'b1;
            if (d == 0 || d > MAXP || (m == 0 && dup)) begin
                mrej[m] = 1'b1;
            end else begin
                mvals[m][mcnt[m]] = d;
                mcnt[m]++;
                if (mcnt[m] == NT) mphase[m] = PH_FIX;
            end
        end
    endfunction

    function automatic logic [31:0] model_taps(input int m);
        logic [31:0] t;
        t = '0;
        for (int k = 0; k < NT; k++) t[k*8 +: 8] = 8'(mvals[m][k]);
        return t;
    endfunction

    task automatic check_outs(input string tag);
        check({tag, "_taps0"},  taps0,        model_taps(0));
        check({tag, "_cnt0"},   32'(cnt0),    32'(mcnt[0]));
        check({tag, "_rej0"},   32'(rej0),    32'(mrej[0]));
        check({tag, "_done0"},  32'(done0),   32'(mdone[0]));
        check({tag, "_taps1"},  taps1,        model_taps(1));
        check({tag, "_cnt1"},   32'(cnt1),    32'(mcnt[1]));
        check({tag, "_rej1"},   32'(rej1),    32'(mrej[1]));
        check({tag, "_done1"},  32'(done1),   32'(mdone[1]));
    endtask

    // One clock: drive inputs, check ready before the edge, advance model, check after.
    task automatic step(input string tag, input bit s, input bit v, input int d);
        logic [3:0] dv;
        dv        = d[3:0];
        start     = s;
        din_valid = v;
        din       = dv;
        #1;
        check({tag, "_rdy0"}, 32'(rdy0), 32'((mphase[0] == PH_COLLECT) && !s));
        check({tag, "_rdy1"}, 32'(rdy1), 32'((mphase[1] == PH_COLLECT) && !s));
        @(posedge clk);
        model_edge(0, s, v, d);
        model_edge(1, s, v, d);
        #1;
        check_outs(tag);
    endtask

    initial begin
        int seq_a[4];
        int seq_b[6];
        n_tests = 0;
        n_fail  = 0;

        // reset held with valid input present
        res       = 1'b0;
        start     = 1'b0;
        din_valid = 1'b1;
        din       = 4'd5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        @(negedge clk);
        res       = 1'b1;
        din_valid = 1'b0;
        #1;
        check("reset_rdy0", 32'(rdy0), 32'd1);
        check("reset_rdy1", 32'(rdy1), 32'd1);

        // 3,7,15,9 back-to-back
        seq_a = '{3, 7, 15, 9};
        foreach (seq_a[i]) step("basic", 1'b0, 1'b1, seq_a[i]);
        check("basic_taps_e", taps0, 32'h090F0703);
        check("basic_cnt_e",  32'(cnt0), 32'd4);
        check("basic_rdy_e",  32'(rdy0), 32'd0);
        step("basic_fix", 1'b0, 1'b0, 0);
        check("basic_done", 32'(done0), 32'd1);
        check("basic_taps_fix", taps0, 32'h090F0703);

        // MAX_POW absent -> forced into slot 0
        step("st1", 1'b1, 1'b1, 4);
        seq_a = '{3, 7, 9, 11};
        foreach (seq_a[i]) step("force", 1'b0, 1'b1, seq_a[i]);
        step("force_fix", 1'b0, 1'b0, 0);
        check("force_taps", taps0, 32'h0B09070F);
        check("force_done", 32'(done0), 32'd1);

        // duplicates and zero
        step("st2", 1'b1, 1'b0, 0);
        seq_b = '{5, 5, 0, 6, 7, 8};
        for (int i = 0; i < 6; i++) begin
            step("dup", 1'b0, 1'b1, seq_b[i]);
            if (i == 1) check("dup_rej_2nd", 32'(rej0), 32'd1);
            if (i == 2) check("zero_rej_nd", 32'(rej1), 32'd1);
            if (i == 4) check("nd_taps_prefix", taps1, 32'h07060505);
        end
        step("dup_fix", 1'b0, 1'b0, 0);
        check("dup_taps", taps0, 32'h0807060F);
        check("nd_taps",  taps1, 32'h0706050F);

        // restart after two accepts
        step("st3", 1'b1, 1'b0, 0);
        step("rs", 1'b0, 1'b1, 1);
        step("rs", 1'b0, 1'b1, 2);
        step("rs_start", 1'b1, 1'b1, 9);
        check("rs_taps_clr", taps0, 32'h0);
        check("rs_cnt_clr",  32'(cnt0), 32'd0);
        seq_a = '{1, 2, 3, 15};
        foreach (seq_a[i]) step("rs", 1'b0, 1'b1, seq_a[i]);
        step("rs_fix", 1'b0, 1'b0, 0);
        check("rs_taps", taps0, 32'h0F030201);

        // din_valid held in DONE
        for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b1, $urandom_range(1, 15));
        check("hold_taps", taps0, 32'h0F030201);

        // asynchronous reset while DONE
        #2;
        res = 1'b0;
        #1;
        model_reset();
        check_outs("async");
        @(negedge clk);
        res = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
